// File: rtl/iob_eth_rx_filter_pkg.sv
// Shared constants for the Ethernet receive frame qualifier: default station
// address, CRC residue, legal length window, FSM encodings and flag positions.
package iob_eth_rx_filter_pkg;

   localparam logic [47:0] ETH_MAC_ADDR_DEF = 48'h02_00_5E_10_20_30;
   localparam logic [47:0] ETH_BCAST_ADDR   = 48'hFF_FF_FF_FF_FF_FF;

   // Register value left in the CRC engine after a frame plus a correct FCS
   localparam logic [31:0] CRC_RESIDUE_DEF  = 32'hC704_DD7B;
   localparam logic [31:0] CRC_POLY         = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT         = 32'hFFFF_FFFF;

   localparam logic [10:0] MIN_LEN_DEF      = 11'd64;
   localparam logic [10:0] MAX_LEN_DEF      = 11'd1518;

   // Parser states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DST     = 3'd1;
   localparam logic [2:0] ST_SRC     = 3'd2;
   localparam logic [2:0] ST_TYPE    = 3'd3;
   localparam logic [2:0] ST_PAYLOAD = 3'd4;

   // Bit positions inside st_flags
   localparam int FLAG_ADDR_MATCH = 0;
   localparam int FLAG_BCAST      = 1;
   localparam int FLAG_CRC_ERR    = 2;
   localparam int FLAG_RUNT       = 3;
   localparam int FLAG_GIANT      = 4;

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-wide Ethernet CRC-32 engine. Bits of each byte are taken LSB first,
// as they appear on the wire; the register is left un-inverted so a frame
// with a correct FCS leaves the fixed residue behind.
module iob_eth_crc
   import iob_eth_rx_filter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        data_en,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   // Restart on reset/start, otherwise fold in each enabled byte
   always_ff @(posedge clk) begin
      if (rst || start)  crc_out <= CRC_INIT;
      else if (data_en)  crc_out <= crc_byte(crc_out, data_in);
   end

endmodule

// File: rtl/iob_eth_rx_filter.sv
// Receive frame qualifier: parses destination/EtherType, counts bytes, checks
// the FCS and posts a one-deep status word taken with a valid/ack handshake.
module iob_eth_rx_filter
   import iob_eth_rx_filter_pkg::*;
#(
   parameter logic [47:0] ETH_MAC_ADDR = ETH_MAC_ADDR_DEF,
   parameter logic [31:0] CRC_RESIDUE  = CRC_RESIDUE_DEF,
   parameter logic [10:0] MIN_LEN      = MIN_LEN_DEF,
   parameter logic [10:0] MAX_LEN      = MAX_LEN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sof,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   input  logic        eof,
   input  logic        promisc,
   output logic        st_valid,
   input  logic        st_ack,
   output logic [10:0] st_len,
   output logic [15:0] st_type,
   output logic [4:0]  st_flags,
   output logic        st_ok,
   output logic [15:0] drop_cnt
);

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [2:0]  state;
   logic [10:0] len;
   logic [47:0] dest;
   logic [15:0] etype;
   logic [31:0] crc_out;

   logic        in_frame, acc, eval, load, drop;
   logic [4:0]  ev_flags;
   logic        ev_ok;
   logic [15:0] ev_type;

   assign in_frame = (state != ST_IDLE);
   // A byte coinciding with sof or eof never belongs to the frame being parsed
   assign acc      = byte_en && in_frame && !eof && !sof;
   assign eval     = eof && in_frame;
   assign load     = eval && (!st_valid || st_ack);
   assign drop     = eval && st_valid && !st_ack;

   iob_eth_crc u_crc (
      .clk     (clk),
      .rst     (rst),
      .start   ((state == ST_IDLE) || sof),
      .data_en (byte_en && in_frame),
      .data_in (byte_in),
      .crc_out (crc_out)
   );

   // Classify the frame from the registered parse results at eof
   always_comb begin
      ev_flags                  = '0;
      ev_flags[FLAG_ADDR_MATCH] = (dest == ETH_MAC_ADDR);
      ev_flags[FLAG_BCAST]      = (dest == ETH_BCAST_ADDR);
      ev_flags[FLAG_CRC_ERR]    = (crc_out != CRC_RESIDUE);
      ev_flags[FLAG_RUNT]       = (len < MIN_LEN);
      ev_flags[FLAG_GIANT]      = (len > MAX_LEN);
      ev_ok = (ev_flags[FLAG_ADDR_MATCH] || ev_flags[FLAG_BCAST] || promisc) &&
              !ev_flags[FLAG_CRC_ERR] && !ev_flags[FLAG_RUNT] && !ev_flags[FLAG_GIANT];
      // A partially received EtherType is reported as unparsed
      ev_type = (len >= 11'd14) ? etype : 16'h0000;
   end

   // Parser FSM; sof restarts from any state, eof closes the frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (sof) begin
         state <= ST_DST;
      end else if (eof) begin
         state <= ST_IDLE;
      end else if (acc) begin
         case (state)
            ST_DST:  if (len == 11'd5)  state <= ST_SRC;
            ST_SRC:  if (len == 11'd11) state <= ST_TYPE;
            ST_TYPE: if (len == 11'd13) state <= ST_PAYLOAD;
            default: ;
         endcase
      end
   end

   // Byte counter and header field capture, cleared at frame start
   always_ff @(posedge clk) begin
      if (sof) begin
         len   <= '0;
         dest  <= '0;
         etype <= '0;
      end else if (acc) begin
         len <= sat_inc11(len);
         if (state == ST_DST)  dest  <= {dest[39:0], byte_in};
         if (state == ST_TYPE) etype <= {etype[7:0], byte_in};
      end
   end

   // One-deep status slot and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         st_valid <= 1'b0;
         st_len   <= '0;
         st_type  <= '0;
         st_flags <= '0;
         st_ok    <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (load) begin
            st_valid <= 1'b1;
            st_len   <= len;
            st_type  <= ev_type;
            st_flags <= ev_flags;
            st_ok    <= ev_ok;
         end else if (st_valid && st_ack) begin
            st_valid <= 1'b0;
         end
         if (drop) drop_cnt <= sat_inc16(drop_cnt);
      end
   end

endmodule

// File: tb/tb_iob_eth_rx_filter.sv
// Scoreboard bench for iob_eth_rx_filter: directed frames with hand-computed
// expected status words; a monitor pops and compares each posted status.
module tb_iob_eth_rx_filter;

   localparam logic [47:0] MY_MAC = 48'h02_00_5E_10_20_30;
   localparam logic [47:0] BC_MAC = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] OT_MAC = 48'h0A_0B_0C_0D_0E_0F;
   localparam logic [47:0] SR_MAC = 48'h00_11_22_33_44_55;

   logic        clk, rst, sof, byte_en, eof, promisc, st_ack;
   logic [7:0]  byte_in;
   logic        st_valid, st_ok;
   logic [10:0] st_len;
   logic [15:0] st_type, drop_cnt;
   logic [4:0]  st_flags;

   iob_eth_rx_filter #(.ETH_MAC_ADDR(MY_MAC)) dut (
      .clk(clk), .rst(rst), .sof(sof), .byte_en(byte_en), .byte_in(byte_in),
      .eof(eof), .promisc(promisc), .st_valid(st_valid), .st_ack(st_ack),
      .st_len(st_len), .st_type(st_type), .st_flags(st_flags), .st_ok(st_ok),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] len;
      logic [15:0] typ;
      logic [4:0]  flags;
      logic        ok;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] frm[$];
   int         checks = 0;
   int         failures = 0;
   logic       valid_at_eof;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_st(input logic [10:0] l, input logic [15:0] t, input logic [4:0] f, input logic ok);
      exp_t e;
      e.len = l; e.typ = t; e.flags = f; e.ok = ok;
      sb.push_back(e);
   endtask

   // Reference FCS in the reflected form used on the wire
   function automatic logic [31:0] fcs_of();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (frm[k]) begin
         c = c ^ {24'd0, frm[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build_frame(input logic [47:0] d, input logic [15:0] t, input int total, input int flip);
      logic [31:0] f;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(SR_MAC[47-8*i -: 8]);
      frm.push_back(t[15:8]);
      frm.push_back(t[7:0]);
      for (int i = 0; i < total - 18; i++) frm.push_back(8'((i * 7 + 3) & 255));
      f = fcs_of();
      frm.push_back(f[7:0]);
      frm.push_back(f[15:8]);
      frm.push_back(f[23:16]);
      frm.push_back(f[31:24]);
      if (flip >= 0) frm[flip] = frm[flip] ^ 8'h10;
   endtask

   // Returns #1 after the edge that samples eof (or the last byte)
   task automatic send(input int n, input bit gaps, input bit do_eof, input bit ack_at_eof);
      @(posedge clk); #1; sof = 1'b1;
      @(posedge clk); #1; sof = 1'b0;
      for (int i = 0; i < n; i++) begin
         byte_en = 1'b1;
         byte_in = frm[i];
         @(posedge clk); #1;
         byte_en = 1'b0;
         if (gaps && (i % 7 == 3)) begin @(posedge clk); #1; end
      end
      if (do_eof) begin
         eof = 1'b1;
         st_ack = ack_at_eof;
         #2 valid_at_eof = st_valid;
         @(posedge clk); #1;
         eof = 1'b0;
         st_ack = 1'b0;
      end
   endtask

   task automatic ack();
      st_ack = 1'b1;
      @(posedge clk); #1;
      st_ack = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(st_valid), 0);
      chk({tag, "_len"},   32'(st_len),   0);
      chk({tag, "_type"},  32'(st_type),  0);
      chk({tag, "_flags"}, 32'(st_flags), 0);
      chk({tag, "_ok"},    32'(st_ok),    0);
      chk({tag, "_drop"},  32'(drop_cnt), 0);
   endtask

   // Monitor: a new status is presented when valid rises or reloads under ack
   logic last_valid = 1'b0;
   logic last_ack   = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst && st_valid && (!last_valid || last_ack)) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_status: got status type=%h len=%0d, required none", st_type, st_len);
         end else begin
            e = sb.pop_front();
            chk("st_len",   32'(st_len),   32'(e.len));
            chk("st_type",  32'(st_type),  32'(e.typ));
            chk("st_flags", 32'(st_flags), 32'(e.flags));
            chk("st_ok",    32'(st_ok),    32'(e.ok));
         end
      end
      last_valid = st_valid;
      last_ack   = st_ack;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sof = 1'b0; byte_en = 1'b0; byte_in = 8'h00; eof = 1'b0;
      promisc = 1'b0; st_ack = 1'b0; valid_at_eof = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_all_zero("reset");

      // Good unicast frame, status held without ack
      build_frame(MY_MAC, 16'h0800, 64, -1);
      expect_st(11'd64, 16'h0800, 5'b00001, 1'b1);
      send(64, 0, 1, 0);
      chk("valid_during_eof", 32'(valid_at_eof), 0);
      chk("valid_after_eof",  32'(st_valid), 1);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_valid", 32'(st_valid), 1);
      chk("hold_len",   32'(st_len), 64);
      ack();
      chk("valid_after_ack", 32'(st_valid), 0);

      // Payload bit flipped
      build_frame(MY_MAC, 16'h0800, 64, 30);
      expect_st(11'd64, 16'h0800, 5'b00101, 1'b0);
      send(64, 0, 1, 0); ack();

      // Broadcast, with idle gaps between bytes
      build_frame(BC_MAC, 16'h0806, 64, -1);
      expect_st(11'd64, 16'h0806, 5'b00010, 1'b1);
      send(64, 1, 1, 0); ack();

      // Foreign unicast, then again in promiscuous mode
      build_frame(OT_MAC, 16'h86DD, 64, -1);
      expect_st(11'd64, 16'h86DD, 5'b00000, 1'b0);
      send(64, 0, 1, 0); ack();
      promisc = 1'b1;
      expect_st(11'd64, 16'h86DD, 5'b00000, 1'b1);
      send(64, 0, 1, 0); ack();
      promisc = 1'b0;

      // Runt, giant, saturating length
      build_frame(MY_MAC, 16'h0800, 60, -1);
      expect_st(11'd60, 16'h0800, 5'b01001, 1'b0);
      send(60, 0, 1, 0); ack();
      build_frame(MY_MAC, 16'h8100, 1522, -1);
      expect_st(11'd1522, 16'h8100, 5'b10001, 1'b0);
      send(1522, 0, 1, 0); ack();
      build_frame(MY_MAC, 16'h8870, 2100, -1);
      expect_st(11'd2047, 16'h8870, 5'b10001, 1'b0);
      send(2100, 0, 1, 0); ack();

      // Ack on the evaluation edge reloads the slot
      build_frame(MY_MAC, 16'h1111, 64, -1);
      expect_st(11'd64, 16'h1111, 5'b00001, 1'b1);
      send(64, 0, 1, 0);
      build_frame(MY_MAC, 16'h2222, 64, -1);
      expect_st(11'd64, 16'h2222, 5'b00001, 1'b1);
      send(64, 0, 1, 1);
      chk("reload_valid", 32'(st_valid), 1);
      chk("reload_type",  32'(st_type), 32'h2222);
      chk("reload_drop",  32'(drop_cnt), 0);
      ack();

      // Slot full: second frame dropped
      build_frame(MY_MAC, 16'h3333, 64, -1);
      expect_st(11'd64, 16'h3333, 5'b00001, 1'b1);
      send(64, 0, 1, 0);
      build_frame(MY_MAC, 16'h4444, 64, -1);
      send(64, 0, 1, 0);
      chk("drop_cnt",  32'(drop_cnt), 1);
      chk("drop_held", 32'(st_type), 32'h3333);
      ack();

      // Abort by sof at byte 20, then a good frame
      build_frame(MY_MAC, 16'h5555, 64, -1);
      send(20, 0, 0, 0);
      build_frame(MY_MAC, 16'h6666, 64, -1);
      expect_st(11'd64, 16'h6666, 5'b00001, 1'b1);
      send(64, 0, 1, 0); ack();

      // Reset mid-frame with a status pending
      build_frame(MY_MAC, 16'h7777, 64, -1);
      expect_st(11'd64, 16'h7777, 5'b00001, 1'b1);
      send(64, 0, 1, 0);
      build_frame(MY_MAC, 16'h8888, 64, -1);
      send(30, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_all_zero("midrst");
      build_frame(MY_MAC, 16'h9999, 64, -1);
      expect_st(11'd64, 16'h9999, 5'b00001, 1'b1);
      send(64, 0, 1, 0);
      chk("post_rst_valid", 32'(st_valid), 1);
      ack();

      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
